uart_hex_seg_mux: RTL and testbench



---
 rtl/uart_hex_seg_mux_pkg.sv | 76 +++++++
 rtl/uart_rx_8n1.sv | 117 +++++++++++
 rtl/uart_hex_seg_mux.sv | 136 +++++++++++++
 tb/tb_uart_hex_seg_mux.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_hex_seg_mux_pkg.sv
// ---------------------------------------------------------------------------
// uart_hex_seg_mux_pkg
// Shared definitions for the UART hex display controller:
//   - ASCII constants used by the character decoder
//   - RX state enumeration for uart_rx_8n1
//   - display digit record (valid flag + nibble)
//   - hex_to_seg   : nibble -> 7-segment glyph (seg[0]=a .. seg[6]=g)
//   - ascii_to_hex : ASCII byte -> {is_hex, nibble}
// ---------------------------------------------------------------------------
package uart_hex_seg_mux_pkg;

    localparam logic [7:0] ASCII_0    = 8'h30;
    localparam logic [7:0] ASCII_A    = 8'h41;
    localparam logic [7:0] ASCII_a    = 8'h61;
    localparam logic [7:0] ASCII_DASH = 8'h2D;

    localparam logic [6:0] SEG_BLANK  = 7'h00;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    typedef struct packed {
        logic       valid;
        logic [3:0] nib;
    } digit_t;

    typedef struct packed {
        logic       is_hex;
        logic [3:0] nib;
    } hex_char_t;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    function automatic hex_char_t ascii_to_hex(input logic [7:0] c);
        hex_char_t r;
        r.is_hex = 1'b0;
        r.nib    = 4'h0;
        if (c >= ASCII_0 && c <= ASCII_0 + 8'd9) begin
            r.is_hex = 1'b1;
            r.nib    = 4'(c - ASCII_0);
        end else if (c >= ASCII_A && c <= ASCII_A + 8'd5) begin
            r.is_hex = 1'b1;
            r.nib    = 4'(c - ASCII_A + 8'd10);
        end else if (c >= ASCII_a && c <= ASCII_a + 8'd5) begin
            r.is_hex = 1'b1;
            r.nib    = 4'(c - ASCII_a + 8'd10);
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_rx_8n1.sv
// ---------------------------------------------------------------------------
// uart_rx_8n1
// 8N1 UART receiver with a 2-flop input synchroniser.
//   clk_i        : system clock
//   rst_i        : asynchronous reset, active-high
//   rx_i         : serial line, idle high, asynchronous to clk_i
//   rx_byte_o    : last received byte (LSB first on the wire)
//   byte_valid_o : 1-cycle pulse, rx_byte_o holds a good frame
//   frame_err_o  : 1-cycle pulse, stop bit sampled low (byte discarded)
//   busy_o       : receiver is not idle
// ---------------------------------------------------------------------------
module uart_rx_8n1
    import uart_hex_seg_mux_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10416
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic [7:0] rx_byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o,
    output logic       busy_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    rx_state_e        state_q;
    logic [1:0]       sync_q;
    logic             armed_q;
    logic [CNT_W-1:0] clk_cnt_q;
    logic [2:0]       bit_cnt_q;
    logic [7:0]       shift_q;
    logic             byte_valid_q;
    logic             frame_err_q;
    logic             rx_s;

    assign rx_s = sync_q[1];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            // Synchroniser resets low and armed_q clear: after reset the line
            // must be seen high before any falling edge counts as a start bit,
            // so a frame cut by reset cannot be picked up half-way.
            sync_q       <= 2'b00;
            armed_q      <= 1'b0;
            state_q      <= RX_IDLE;
            clk_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            sync_q       <= {sync_q[0], rx_i};
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            if (rx_s) begin
                armed_q <= 1'b1;
            end

            case (state_q)
                RX_IDLE: begin
                    if (armed_q && !rx_s) begin
                        state_q   <= RX_START;
                        clk_cnt_q <= '0;
                        bit_cnt_q <= '0;
                    end
                end
                RX_START: begin
                    if (clk_cnt_q == HALF_M1) begin
                        // Mid-start re-check; a high line here was a glitch.
                        clk_cnt_q <= '0;
                        state_q   <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (clk_cnt_q == FULL_M1) begin
                        clk_cnt_q <= '0;
                        shift_q   <= {rx_s, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= RX_STOP;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (clk_cnt_q == FULL_M1) begin
                        clk_cnt_q <= '0;
                        state_q   <= RX_IDLE;
                        if (rx_s) begin
                            byte_valid_q <= 1'b1;
                        end else begin
                            frame_err_q  <= 1'b1;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= RX_IDLE;
            endcase
        end
    end

    assign rx_byte_o    = shift_q;
    assign byte_valid_o = byte_valid_q;
    assign frame_err_o  = frame_err_q;
    assign busy_o       = (state_q != RX_IDLE);

endmodule

// File: rtl/uart_hex_seg_mux.sv
// ---------------------------------------------------------------------------
// uart_hex_seg_mux
// UART-driven N-digit multiplexed seven-segment display controller.
// Hex characters received over 8N1 serial shift into a digit buffer
// (newest digit on the right); '-' blanks the display.
//   CLK100MHZ : system clock
//   RST       : asynchronous reset, active-high
//   uart_rx   : serial input, idle high
//   seg       : segments, seg[0]=a .. seg[6]=g (inverted if SEG_ACTIVE_LOW)
//   digit_sel : index of the digit currently driven, 0 = rightmost
//   led       : [0] frame error (sticky), [1] invalid char (sticky),
//               [2] rx busy, [3] toggles on each accepted hex char
// ---------------------------------------------------------------------------
module uart_hex_seg_mux
    import uart_hex_seg_mux_pkg::*;
#(
    parameter int  CLKS_PER_BIT   = 10416,
    parameter int  NUM_DIGITS     = 2,
    parameter int  REFRESH_CYCLES = 100000,
    parameter bit  SEG_ACTIVE_LOW = 1'b0,
    localparam int SEL_W          = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic             CLK100MHZ,
    input  logic             RST,
    input  logic             uart_rx,
    output logic [6:0]       seg,
    output logic [SEL_W-1:0] digit_sel,
    output logic [3:0]       led
);

    localparam int REF_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_CYCLES - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_DIGITS - 1);
    localparam logic [6:0]       SEG_OFF  = SEG_ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;

    logic [7:0] rx_byte;
    logic       byte_valid;
    logic       frame_err;
    logic       rx_busy;

    uart_rx_8n1 #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk_i        (CLK100MHZ),
        .rst_i        (RST),
        .rx_i         (uart_rx),
        .rx_byte_o    (rx_byte),
        .byte_valid_o (byte_valid),
        .frame_err_o  (frame_err),
        .busy_o       (rx_busy)
    );

    // ---------------- character decode and display buffer ----------------
    digit_t [NUM_DIGITS-1:0] disp_q, disp_d;
    logic                    frame_led_q, frame_led_d;
    logic                    inval_led_q, inval_led_d;
    logic                    toggle_q, toggle_d;
    hex_char_t               hc;
    digit_t                  new_digit;

    assign hc              = ascii_to_hex(rx_byte);
    assign new_digit.valid = 1'b1;
    assign new_digit.nib   = hc.nib;

    // NOTE: every output of this block is given its hold value first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        disp_d      = disp_q;
        frame_led_d = frame_led_q;
        inval_led_d = inval_led_q;
        toggle_d    = toggle_q;

        if (frame_err) begin
            frame_led_d = 1'b1;
        end

        if (byte_valid) begin
            if (hc.is_hex) begin
                // Shift left by one digit; the oldest digit falls off the top.
                disp_d   = {disp_q[NUM_DIGITS-2:0], new_digit};
                toggle_d = ~toggle_q;
            end else if (rx_byte == ASCII_DASH) begin
                disp_d      = '0;
                frame_led_d = 1'b0;
                inval_led_d = 1'b0;
            end else begin
                inval_led_d = 1'b1;
            end
        end
    end

    // ---------------- refresh multiplexer ----------------
    logic [REF_W-1:0] ref_cnt_q;
    logic [SEL_W-1:0] sel_q, sel_next;
    logic [6:0]       seg_q, seg_raw, seg_next;

    // Explicit wrap keeps the sequence 0..NUM_DIGITS-1 for non-power-of-2 counts.
    assign sel_next = (sel_q == SEL_LAST) ? '0 : sel_q + SEL_W'(1);

    // Encoded from the registered buffer, so a write landing on the same edge
    // is shown at that digit's next refresh rather than mixed into this one.
    assign seg_raw  = disp_q[sel_next].valid ? hex_to_seg(disp_q[sel_next].nib) : SEG_BLANK;
    assign seg_next = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;

    always_ff @(posedge CLK100MHZ or posedge RST) begin
        if (RST) begin
            // NOTE: the digit buffer is reset because a blank display after
            // reset is part of the visible behaviour, not just initialisation.
            disp_q      <= '0;
            frame_led_q <= 1'b0;
            inval_led_q <= 1'b0;
            toggle_q    <= 1'b0;
            ref_cnt_q   <= '0;
            sel_q       <= '0;
            seg_q       <= SEG_OFF;
        end else begin
            disp_q      <= disp_d;
            frame_led_q <= frame_led_d;
            inval_led_q <= inval_led_d;
            toggle_q    <= toggle_d;
            if (ref_cnt_q == REF_LAST) begin
                // seg and digit_sel change on the same edge: no ghosting.
                ref_cnt_q <= '0;
                sel_q     <= sel_next;
                seg_q     <= seg_next;
            end else begin
                ref_cnt_q <= ref_cnt_q + REF_W'(1);
            end
        end
    end

    assign seg       = seg_q;
    assign digit_sel = sel_q;
    assign led       = {toggle_q, rx_busy, inval_led_q, frame_led_q};

endmodule

// File: tb/tb_uart_hex_seg_mux.sv
// ---------------------------------------------------------------------------
// tb_uart_hex_seg_mux
// Self-checking bench: a 4-digit active-high instance driven by a table of
// characters with hand-derived expected glyphs, then by random characters
// checked against a queue-based display model; a 3-digit active-low instance
// covers non-power-of-2 wrap, inverted segments and reset in mid-frame.
// ---------------------------------------------------------------------------
module tb_uart_hex_seg_mux;

    localparam int CPB = 16;
    localparam int REF = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx4 = 1'b1;
    logic       rx3 = 1'b1;
    logic [6:0] seg4, seg3;
    logic [1:0] sel4, sel3;
    logic [3:0] led4, led3;

    int vectors     = 0;
    int miscompares = 0;
    int edges;

    logic [6:0] exp4 [4];
    logic [6:0] exp3 [3];
    logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    typedef struct {
        logic [7:0]  ch;
        bit          stop_ok;
        logic [27:0] segs;   // {digit3, digit2, digit1, digit0}
        logic [3:0]  led;
    } vec_t;

    localparam int NV = 23;
    vec_t tbl [NV];

    // Random-phase model: digq[0] is the rightmost digit, -1 means blank.
    int digq [$];
    bit m_frame, m_inval, m_tog;

    uart_hex_seg_mux #(
        .CLKS_PER_BIT   (CPB),
        .NUM_DIGITS     (4),
        .REFRESH_CYCLES (REF),
        .SEG_ACTIVE_LOW (1'b0)
    ) dut (
        .CLK100MHZ (clk),
        .RST       (rst),
        .uart_rx   (rx4),
        .seg       (seg4),
        .digit_sel (sel4),
        .led       (led4)
    );

    uart_hex_seg_mux #(
        .CLKS_PER_BIT   (CPB),
        .NUM_DIGITS     (3),
        .REFRESH_CYCLES (REF),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut3 (
        .CLK100MHZ (clk),
        .RST       (rst),
        .uart_rx   (rx3),
        .seg       (seg3),
        .digit_sel (sel3),
        .led       (led3)
    );

    always #5 clk = ~clk;

    // Clock edges since reset release: digit k is selected for edges in
    // [8m, 8m+7] where m mod N == k.
    always @(posedge clk or posedge rst) begin
        if (rst) edges <= 0;
        else     edges <= edges + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_line(input bit is3, input logic v);
        if (is3) rx3 = v;
        else     rx4 = v;
    endtask

    task automatic send_byte(input bit is3, input logic [7:0] b, input bit stop_ok);
        set_line(is3, 1'b0);
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            set_line(is3, b[i]);
            repeat (CPB) @(negedge clk);
        end
        set_line(is3, stop_ok);
        repeat (CPB) @(negedge clk);
        set_line(is3, 1'b1);
        repeat (2 * CPB) @(negedge clk);
    endtask

    // Checks digit_sel and seg every cycle for the given number of cycles.
    task automatic check_rotation(input bit is3, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            int es;
            @(negedge clk);
            es = (edges / REF) % (is3 ? 3 : 4);
            if (is3) begin
                check("digit_sel3", {30'd0, sel3}, es);
                check("seg3", {25'd0, seg3}, {25'd0, exp3[es]});
            end else begin
                check("digit_sel4", {30'd0, sel4}, es);
                check("seg4", {25'd0, seg4}, {25'd0, exp4[es]});
            end
        end
    endtask

    function automatic int hexval(input logic [7:0] c);
        int v;
        v = int'(c);
        if (v >= 48 && v <= 57)  return v - 48;
        if (v >= 65 && v <= 70)  return v - 65 + 10;
        if (v >= 97 && v <= 102) return v - 97 + 10;
        return -1;
    endfunction

    task automatic model_apply(input logic [7:0] b, input bit stop_ok);
        int h;
        h = hexval(b);
        if (!stop_ok) begin
            m_frame = 1'b1;
        end else if (h >= 0) begin
            digq.push_front(h);
            void'(digq.pop_back());
            m_tog = ~m_tog;
        end else if (b == 8'h2D) begin
            foreach (digq[i]) digq[i] = -1;
            m_frame = 1'b0;
            m_inval = 1'b0;
        end else begin
            m_inval = 1'b1;
        end
        for (int d = 0; d < 4; d++) exp4[d] = (digq[d] < 0) ? 7'h00 : glyph[digq[d]];
    endtask

    task automatic model_send_check(input logic [7:0] b, input bit stop_ok);
        model_apply(b, stop_ok);
        send_byte(1'b0, b, stop_ok);
        repeat (4 * REF) @(negedge clk);
        check_rotation(1'b0, 4 * REF);
        check("led4_model", {28'd0, led4}, {28'd0, m_tog, 1'b0, m_inval, m_frame});
    endtask

    initial begin
        string hexchars;
        hexchars = "0123456789ABCDEFabcdef";

        tbl[0]  = '{8'h35, 1'b1, {7'h00, 7'h00, 7'h00, 7'h6D}, 4'b1000}; // '5'
        tbl[1]  = '{8'h31, 1'b1, {7'h00, 7'h00, 7'h6D, 7'h06}, 4'b0000}; // '1'
        tbl[2]  = '{8'h32, 1'b1, {7'h00, 7'h6D, 7'h06, 7'h5B}, 4'b1000}; // '2'
        tbl[3]  = '{8'h33, 1'b1, {7'h6D, 7'h06, 7'h5B, 7'h4F}, 4'b0000}; // '3'
        tbl[4]  = '{8'h34, 1'b1, {7'h06, 7'h5B, 7'h4F, 7'h66}, 4'b1000}; // '4'
        tbl[5]  = '{8'h45, 1'b1, {7'h5B, 7'h4F, 7'h66, 7'h79}, 4'b0000}; // 'E'
        tbl[6]  = '{8'h41, 1'b0, {7'h5B, 7'h4F, 7'h66, 7'h79}, 4'b0001}; // 'A', bad stop
        tbl[7]  = '{8'h7A, 1'b1, {7'h5B, 7'h4F, 7'h66, 7'h79}, 4'b0011}; // 'z'
        tbl[8]  = '{8'h2D, 1'b1, {7'h00, 7'h00, 7'h00, 7'h00}, 4'b0000}; // '-'
        tbl[9]  = '{8'h61, 1'b1, {7'h00, 7'h00, 7'h00, 7'h77}, 4'b1000}; // 'a'
        tbl[10] = '{8'h62, 1'b1, {7'h00, 7'h00, 7'h77, 7'h7C}, 4'b0000}; // 'b'
        tbl[11] = '{8'h43, 1'b1, {7'h00, 7'h77, 7'h7C, 7'h39}, 4'b1000}; // 'C'
        tbl[12] = '{8'h64, 1'b1, {7'h77, 7'h7C, 7'h39, 7'h5E}, 4'b0000}; // 'd'
        tbl[13] = '{8'h40, 1'b1, {7'h77, 7'h7C, 7'h39, 7'h5E}, 4'b0010}; // '@'
        tbl[14] = '{8'h67, 1'b1, {7'h77, 7'h7C, 7'h39, 7'h5E}, 4'b0010}; // 'g'
        tbl[15] = '{8'h39, 1'b1, {7'h7C, 7'h39, 7'h5E, 7'h6F}, 4'b1010}; // '9'
        tbl[16] = '{8'h3A, 1'b1, {7'h7C, 7'h39, 7'h5E, 7'h6F}, 4'b1010}; // ':'
        tbl[17] = '{8'h66, 1'b1, {7'h39, 7'h5E, 7'h6F, 7'h71}, 4'b0010}; // 'f'
        tbl[18] = '{8'h30, 1'b1, {7'h5E, 7'h6F, 7'h71, 7'h3F}, 4'b1010}; // '0'
        tbl[19] = '{8'h38, 1'b1, {7'h6F, 7'h71, 7'h3F, 7'h7F}, 4'b0010}; // '8'
        tbl[20] = '{8'h47, 1'b1, {7'h6F, 7'h71, 7'h3F, 7'h7F}, 4'b0010}; // 'G'
        tbl[21] = '{8'h2F, 1'b1, {7'h6F, 7'h71, 7'h3F, 7'h7F}, 4'b0010}; // '/'
        tbl[22] = '{8'h37, 1'b1, {7'h71, 7'h3F, 7'h7F, 7'h07}, 4'b1010}; // '7'

        // ---- reset state and idle refresh sequence ----
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 4; d++) exp4[d] = 7'h00;
        for (int d = 0; d < 3; d++) exp3[d] = 7'h7F;
        check_rotation(1'b0, 5 * REF);
        check("led4_reset", {28'd0, led4}, 32'd0);
        check_rotation(1'b1, 4 * REF);
        check("led3_reset", {28'd0, led3}, 32'd0);

        // ---- table-driven vectors ----
        for (int i = 0; i < NV; i++) begin
            send_byte(1'b0, tbl[i].ch, tbl[i].stop_ok);
            repeat (4 * REF) @(negedge clk);
            for (int d = 0; d < 4; d++) exp4[d] = tbl[i].segs[d*7 +: 7];
            check_rotation(1'b0, 4 * REF);
            check("led4_vec", {28'd0, led4}, {28'd0, tbl[i].led});
        end

        // ---- short low pulse on idle line: start rejected, no error ----
        rx4 = 1'b0;
        repeat (4) @(negedge clk);
        check("glitch_busy", {31'd0, led4[2]}, 32'd1);
        rx4 = 1'b1;
        repeat (16) @(negedge clk);
        check("glitch_led", {28'd0, led4}, {28'd0, tbl[NV-1].led});
        check_rotation(1'b0, 4 * REF);

        // ---- randomized characters against the queue model ----
        digq    = {-1, -1, -1, -1};
        m_frame = 1'b0;
        m_inval = 1'b0;
        m_tog   = tbl[NV-1].led[3];
        model_send_check(8'h2D, 1'b1);
        repeat (24) begin
            logic [7:0] b;
            int         r;
            bit         ok;
            r = int'($urandom_range(9));
            if (r < 5)       b = hexchars[$urandom_range(21)];
            else if (r == 5) b = 8'h2D;
            else             b = 8'($urandom_range(255));
            ok = ($urandom_range(7) != 0);
            model_send_check(b, ok);
        end

        // ---- 3-digit active-low instance ----
        send_byte(1'b1, 8'h61, 1'b1);
        repeat (4 * REF) @(negedge clk);
        exp3[0] = 7'h08;
        exp3[1] = 7'h7F;
        exp3[2] = 7'h7F;
        check_rotation(1'b1, 4 * REF);
        check("led3_a", {28'd0, led3}, 32'h8);

        // ---- reset in the middle of a frame ----
        rx3 = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        check("busy3_midframe", {31'd0, led3[2]}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_seg3", {25'd0, seg3}, 32'h7F);
        check("rst_sel3", {30'd0, sel3}, 32'd0);
        check("rst_led3", {28'd0, led3}, 32'd0);
        check("rst_seg4", {25'd0, seg4}, 32'd0);
        check("rst_sel4", {30'd0, sel4}, 32'd0);
        check("rst_led4", {28'd0, led4}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        // Line still low after reset: no restart until it has been high.
        repeat (40) @(negedge clk);
        check("held_low_after_rst", {28'd0, led3}, 32'd0);
        rx3 = 1'b1;
        repeat (8) @(negedge clk);
        send_byte(1'b1, 8'h37, 1'b1);
        repeat (4 * REF) @(negedge clk);
        exp3[0] = 7'h78;
        exp3[1] = 7'h7F;
        exp3[2] = 7'h7F;
        check_rotation(1'b1, 3 * REF);
        check("led3_after_rst", {28'd0, led3}, 32'h8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
